// File: rtl/mem_pkg.sv
// Shared definitions for blocks that act as initiator on the single-port
// memory bus: the copy-engine FSM states and the byte stride of one word.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Byte distance between consecutive 32-bit words.
  localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/dma_copy.sv
// dma_copy: word-by-word memory copy engine acting as bus initiator on a
// shared single-port memory.  Each word takes one READ cycle (ReadData is
// captured at the closing edge) and one WRITE cycle (write commits at the
// closing edge), followed by a single FIN cycle that pulses done.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      copy request, sampled only in IDLE
//   src, dst   word-aligned byte addresses of the first source/dest word
//   len        number of 32-bit words to copy
//   ReadData   memory read data, combinational from Adr
//   MemWrite   memory write enable
//   Adr        memory byte address
//   WriteData  memory write data
//   busy       high whenever the engine is not IDLE
//   done       one-cycle pulse in FIN
//   err        one-cycle pulse after a misaligned start was rejected
module dma_copy #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      ReadData,
  output logic             MemWrite,
  output logic [31:0]      Adr,
  output logic [31:0]      WriteData,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import mem_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_src_ptr;
  logic [31:0]      r_dst_ptr;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_data;
  logic             r_err;
  logic             w_misalign;
  logic             w_len_zero;

  assign w_misalign = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
  assign w_len_zero = (len == '0);

  // Misalignment is checked before len=0, so a misaligned zero-length
  // request is still rejected with err.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start && !w_misalign) begin
          w_next = w_len_zero ? FIN : READ;
        end
      end
      READ:    w_next = WRITE;
      WRITE:   w_next = (r_cnt == LEN_W'(1)) ? FIN : READ;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus outputs decode straight from the state register, so an asynchronous
  // reset drops MemWrite before the next edge and a pending write never commits.
  always_comb begin
    MemWrite  = 1'b0;
    Adr       = 32'd0;
    WriteData = 32'd0;
    case (r_state)
      READ: begin
        Adr = r_src_ptr;
      end
      WRITE: begin
        MemWrite  = 1'b1;
        Adr       = r_dst_ptr;
        WriteData = r_data;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == FIN);
  assign err  = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_src_ptr <= 32'd0;
      r_dst_ptr <= 32'd0;
      r_cnt     <= '0;
      r_data    <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == IDLE) && start && w_misalign;
      case (r_state)
        IDLE: begin
          if (start && !w_misalign && !w_len_zero) begin
            r_src_ptr <= src;
            r_dst_ptr <= dst;
            r_cnt     <= len;
          end
        end
        READ: begin
          r_data <= ReadData;
        end
        WRITE: begin
          // 32-bit adds wrap silently past 0xFFFFFFFC.
          r_src_ptr <= r_src_ptr + WORD_STRIDE;
          r_dst_ptr <= r_dst_ptr + WORD_STRIDE;
          r_cnt     <= r_cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
module tb_dma_copy;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [7:0]  len;
  logic [31:0] ReadData;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        busy;
  logic        done;
  logic        err;

  dma_copy #(.LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .ReadData  (ReadData),
    .MemWrite  (MemWrite),
    .Adr       (Adr),
    .WriteData (WriteData),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256-word memory indexed by Adr[9:2]; the bench preloads it through its
  // own write port while the DUT is idle.
  logic [31:0] mem [0:255];
  logic        tb_we;
  logic [7:0]  tb_idx;
  logic [31:0] tb_wdata;

  assign ReadData = mem[Adr[9:2]];

  always @(posedge clk) begin
    if (MemWrite) mem[Adr[9:2]] = WriteData;
    else if (tb_we) mem[tb_idx] = tb_wdata;
  end

  int n_checks;
  int n_fail;

  logic [31:0] rec_adr  [0:15];
  logic [31:0] rec_wd   [0:15];
  logic        rec_mw   [0:15];
  logic        rec_busy [0:15];
  logic        rec_done [0:15];
  logic        rec_err  [0:15];

  task automatic load_word(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    tb_idx = idx; tb_wdata = val; tb_we = 1'b1;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Pulse start at one edge, then record outputs at the negedge of cycles
  // 1..n after that edge.  A second start can be injected during cycle inj.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l,
                     input int n, input int inj,
                     input logic [31:0] s2, input logic [31:0] d2, input logic [7:0] l2);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rec_adr[k]  = Adr;
      rec_wd[k]   = WriteData;
      rec_mw[k]   = MemWrite;
      rec_busy[k] = busy;
      rec_done[k] = done;
      rec_err[k]  = err;
      start = 1'b0;
      if (k == inj) begin
        src = s2; dst = d2; len = l2; start = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if ({MemWrite, busy, done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got mw/busy/done/err=%b required 0000", {MemWrite, busy, done, err});
    end
    n_checks++;
    if (Adr !== 32'd0 || WriteData !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got Adr=%h WriteData=%h required 0/0", Adr, WriteData);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_copy3;
    logic [31:0] exp_adr;
    logic [31:0] exp_wd;
    run(32'h0, 32'h80, 8'd3, 9, 0, 32'h0, 32'h0, 8'd0);
    for (int k = 1; k <= 9; k++) begin
      exp_adr = 32'd0;
      exp_wd  = 32'd0;
      case (k)
        1: exp_adr = 32'h00;
        2: begin exp_adr = 32'h80; exp_wd = 32'h11; end
        3: exp_adr = 32'h04;
        4: begin exp_adr = 32'h84; exp_wd = 32'h22; end
        5: exp_adr = 32'h08;
        6: begin exp_adr = 32'h88; exp_wd = 32'h33; end
        default: ;
      endcase
      n_checks++;
      if (rec_mw[k] !== (k == 2 || k == 4 || k == 6)) begin
        n_fail++;
        $display("FAIL copy3_memwrite cycle %0d: got %b", k, rec_mw[k]);
      end
      n_checks++;
      if (rec_done[k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL copy3_done cycle %0d: got %b", k, rec_done[k]);
      end
      n_checks++;
      if (rec_busy[k] !== (k <= 7)) begin
        n_fail++;
        $display("FAIL copy3_busy cycle %0d: got %b", k, rec_busy[k]);
      end
      n_checks++;
      if (rec_adr[k] !== exp_adr || rec_wd[k] !== exp_wd) begin
        n_fail++;
        $display("FAIL copy3_bus cycle %0d: got Adr=%h WD=%h required Adr=%h WD=%h",
                 k, rec_adr[k], rec_wd[k], exp_adr, exp_wd);
      end
    end
    n_checks++;
    if (mem[32] !== 32'h11 || mem[33] !== 32'h22 || mem[34] !== 32'h33) begin
      n_fail++;
      $display("FAIL copy3_data: got %h %h %h required 11 22 33", mem[32], mem[33], mem[34]);
    end
    n_checks++;
    if (mem[35] !== 32'hDEAD0023) begin
      n_fail++;
      $display("FAIL copy3_overrun: got %h required DEAD0023", mem[35]);
    end
  endtask

  task automatic test_len0;
    run(32'h0, 32'hE0, 8'd0, 4, 0, 32'h0, 32'h0, 8'd0);
    n_checks++;
    if (rec_busy[1] !== 1'b1 || rec_done[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL len0_fin: got busy=%b done=%b required 1/1", rec_busy[1], rec_done[1]);
    end
    n_checks++;
    if (rec_busy[2] !== 1'b0 || rec_done[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_idle: got busy=%b done=%b required 0/0", rec_busy[2], rec_done[2]);
    end
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (rec_mw[k] !== 1'b0 || rec_adr[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL len0_noaccess cycle %0d: got mw=%b Adr=%h", k, rec_mw[k], rec_adr[k]);
      end
    end
  endtask

  task automatic test_misalign;
    run(32'h2, 32'hA0, 8'd3, 4, 0, 32'h0, 32'h0, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (rec_err[k] !== (k == 1)) begin
        n_fail++;
        $display("FAIL misalign_err cycle %0d: got %b", k, rec_err[k]);
      end
      n_checks++;
      if (rec_busy[k] !== 1'b0 || rec_mw[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_idle cycle %0d: got busy=%b mw=%b", k, rec_busy[k], rec_mw[k]);
      end
    end
    n_checks++;
    if (mem[40] !== 32'hDEAD0028) begin
      n_fail++;
      $display("FAIL misalign_mem: got %h required DEAD0028", mem[40]);
    end
    // Misaligned dst with len=0: still an error, never reaches FIN.
    run(32'h0, 32'hA1, 8'd0, 2, 0, 32'h0, 32'h0, 8'd0);
    n_checks++;
    if (rec_err[1] !== 1'b1 || rec_done[1] !== 1'b0 || rec_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_len0: got err=%b done=%b busy=%b required 1/0/0",
               rec_err[1], rec_done[1], rec_busy[1]);
    end
  endtask

  task automatic test_busy_start;
    run(32'h0, 32'h90, 8'd3, 10, 3, 32'h40, 32'hC0, 8'd1);
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (rec_done[k] !== (k == 7) || rec_busy[k] !== (k <= 7)) begin
        n_fail++;
        $display("FAIL busystart_ctrl cycle %0d: got done=%b busy=%b", k, rec_done[k], rec_busy[k]);
      end
    end
    n_checks++;
    if (mem[36] !== 32'h11 || mem[37] !== 32'h22 || mem[38] !== 32'h33) begin
      n_fail++;
      $display("FAIL busystart_data: got %h %h %h required 11 22 33", mem[36], mem[37], mem[38]);
    end
    n_checks++;
    if (mem[48] !== 32'hDEAD0030) begin
      n_fail++;
      $display("FAIL busystart_second: got %h required DEAD0030", mem[48]);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    src = 32'h0; dst = 32'h100; len = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    // Cycle 4: write of word 2 is on the bus.
    n_checks++;
    if (MemWrite !== 1'b1 || Adr !== 32'h104) begin
      n_fail++;
      $display("FAIL resetmid_setup: got mw=%b Adr=%h required 1/00000104", MemWrite, Adr);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (MemWrite !== 1'b0 || Adr !== 32'd0 || WriteData !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL resetmid_async: got mw=%b Adr=%h WD=%h busy=%b required all 0",
               MemWrite, Adr, WriteData, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || MemWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL resetmid_after step %0d: got done=%b busy=%b mw=%b", k, done, busy, MemWrite);
      end
    end
    n_checks++;
    if (mem[64] !== 32'h11 || mem[65] !== 32'hDEAD0041 || mem[66] !== 32'hDEAD0042) begin
      n_fail++;
      $display("FAIL resetmid_mem: got %h %h %h required 11 DEAD0041 DEAD0042",
               mem[64], mem[65], mem[66]);
    end
  endtask

  task automatic test_wrap;
    run(32'hFFFF_FFFC, 32'h200, 8'd2, 6, 0, 32'h0, 32'h0, 8'd0);
    n_checks++;
    if (rec_adr[1] !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_read1: got %h required FFFFFFFC", rec_adr[1]);
    end
    n_checks++;
    if (rec_adr[3] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_read2: got %h required 00000000", rec_adr[3]);
    end
    n_checks++;
    if (rec_adr[2] !== 32'h200 || rec_adr[4] !== 32'h204) begin
      n_fail++;
      $display("FAIL wrap_writes: got %h %h required 200 204", rec_adr[2], rec_adr[4]);
    end
    n_checks++;
    if (rec_done[5] !== 1'b1 || rec_done[4] !== 1'b0 || rec_done[6] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done: got c4=%b c5=%b c6=%b required 0 1 0",
               rec_done[4], rec_done[5], rec_done[6]);
    end
    n_checks++;
    if (mem[128] !== 32'hAAAA5555 || mem[129] !== 32'h11) begin
      n_fail++;
      $display("FAIL wrap_data: got %h %h required AAAA5555 00000011", mem[128], mem[129]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    src      = 32'd0;
    dst      = 32'd0;
    len      = 8'd0;
    tb_we    = 1'b0;
    tb_idx   = 8'd0;
    tb_wdata = 32'd0;

    test_reset;

    for (int i = 0; i < 256; i++) load_word(8'(i), 32'hDEAD0000 | 32'(i));
    load_word(8'd0, 32'h11);
    load_word(8'd1, 32'h22);
    load_word(8'd2, 32'h33);
    load_word(8'd255, 32'hAAAA5555);

    test_copy3;
    test_len0;
    test_misalign;
    test_busy_start;
    test_reset_mid;
    test_wrap;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
